// File: rtl/hm_pkg.sv
// Shared definitions for the heart-rate measurement path: FSM state type and
// default alarm thresholds also used by the downstream display/alarm logic.
package hm_pkg;

    typedef enum logic {ALIGN, MEASURE} rate_state_t;

    localparam int HM_LOW_TH  = 40;
    localparam int HM_HIGH_TH = 120;

endpackage

// File: rtl/beat_edge_detector.sv
// Synchronises the raw beat input, detects rising edges and applies a
// refractory lockout so contact bounce yields a single accepted beat.
module beat_edge_detector #(
    parameter int REFRACT_CYC = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_in,
    output logic beat_accept
);

    localparam int LW = $clog2(REFRACT_CYC + 1);

    logic          s1_q, s2_q, s3_q;
    logic [LW-1:0] lockout_q, lockout_d;
    logic          edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            lockout_q <= '0;
        end else begin
            s1_q      <= beat_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            lockout_q <= lockout_d;
        end
    end

    assign edge_det    = s2_q & ~s3_q;
    assign beat_accept = edge_det && (lockout_q == '0);

    // Edges seen during lockout are dropped outright, never deferred.
    always_comb begin
        lockout_d = lockout_q;
        if (beat_accept) begin
            lockout_d = LW'(REFRACT_CYC);
        end else if (lockout_q != '0) begin
            lockout_d = lockout_q - LW'(1);
        end
    end

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts accepted beats per window tick and publishes rate plus low/high
// alarms over a valid/ready interface, flagging overwritten results.
module pulse_rate_meter
    import hm_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int REFRACT_CYC = 200,
    parameter int LOW_TH      = HM_LOW_TH,
    parameter int HIGH_TH     = HM_HIGH_TH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             window_tick,
    input  logic             beat_in,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             low_alarm,
    output logic             high_alarm,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LOW_V   = CNT_W'(LOW_TH);
    localparam logic [CNT_W-1:0] HIGH_V  = CNT_W'(HIGH_TH);

    logic beat_accept;

    beat_edge_detector #(
        .REFRACT_CYC(REFRACT_CYC)
    ) u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_in    (beat_in),
        .beat_accept(beat_accept)
    );

    rate_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             low_q, low_d;
    logic             high_q, high_d;
    logic             ovr_q, ovr_d;
    logic             publish, transfer;

    assign publish  = (state_q == MEASURE) && window_tick;
    assign transfer = valid_q && rate_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rate_d  = rate_q;
        low_d   = low_q;
        high_d  = high_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;

        if (state_q == ALIGN) begin
            // Partial first window after reset is discarded.
            count_d = '0;
            if (window_tick) begin
                state_d = MEASURE;
            end
        end else if (window_tick) begin
            count_d = beat_accept ? CNT_W'(1) : '0;
        end else if (beat_accept && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end

        if (publish) begin
            rate_d  = count_q;
            low_d   = (count_q < LOW_V);
            high_d  = (count_q > HIGH_V);
            valid_d = 1'b1;
            ovr_d   = valid_q && !rate_ready;
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGN;
            count_q <= '0;
            rate_q  <= '0;
            low_q   <= 1'b0;
            high_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rate_q  <= rate_d;
            low_q   <= low_d;
            high_q  <= high_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = valid_q;
    assign low_alarm  = low_q;
    assign high_alarm = high_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/pulse_rate_meter.md
Name: pulse_rate_meter

Overview:
- Consumer of the periodic window tick produced by the team's delay counter; it measures sensor beat pulses per window.
- Synchronises the asynchronous beat_in and edge-detects it, rejecting bounce with a refractory lockout.
- Counts accepted beats between consecutive window ticks. At each tick it latches the count and low/high alarm flags, and presents them on a valid/ready interface to the display/alarm logic.

Parameters:
CNT_W, 8, width of beat counter and rate output
REFRACT_CYC, 200, clocks after an accepted beat during which further edges are ignored (>=1)
LOW_TH, 40, rate strictly below this sets low_alarm
HIGH_TH, 120, rate strictly above this sets high_alarm

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
window_tick  in  1  one-cycle pulse marking a window boundary (delay counter done pulse)
beat_in  in  1  raw sensor pulse, asynchronous to clk
rate  out  CNT_W  beats counted in the last complete window
rate_valid  out  1  rate/alarms hold a result not yet accepted
rate_ready  in  1  downstream accepts result when high with rate_valid
low_alarm  out  1  latched with rate: rate < LOW_TH
high_alarm  out  1  latched with rate: rate > HIGH_TH
overrun  out  1  one-cycle pulse: unaccepted result overwritten

Behaviour:
- Reset (async, rst_n=0) clears everything to 0: rate, rate_valid, low_alarm, high_alarm, overrun, count, lockout, sync flops. The FSM enters ALIGN. Reset mid-window discards the partial count.
- Sync/edge: two flops s1, s2, then a previous-value flop s3. The edge condition is s2 & ~s3.
  - A beat_in rise settling before clock edge k is counted at edge k+2.
  - The edge condition is true in the cycle after edge k+1.
- Refractory: an edge is accepted only when lockout==0.
  - Acceptance loads lockout with REFRACT_CYC. Lockout decrements by 1 each cycle while non-zero.
  - Edges while lockout != 0 are dropped, not queued.
  - Lockout runs independently of window_tick.
- FSM, two states:
  - ALIGN: accepted edges are ignored; count is held at 0. On window_tick, go to MEASURE with count=0. No result is produced for the partial first window.
  - MEASURE: each accepted edge does count+1, saturating at 2^CNT_W-1 (no wrap). On window_tick, publish the result and restart the count.
- Publish (MEASURE and window_tick, same clock edge):
  - rate <= count.
  - low_alarm <= (count < LOW_TH); high_alarm <= (count > HIGH_TH). Compare unsigned at CNT_W width.
  - rate_valid <= 1.
  - The new window's count becomes 0, or 1 if an accepted edge coincides with window_tick. A coincident beat belongs to the new window.
- Latency: result appears the cycle after the tick edge.
- Handshake:
  - Transfer occurs on a clock edge with rate_valid & rate_ready; rate_valid clears the next cycle unless a publish occurs on that same edge.
  - rate, low_alarm and high_alarm stay stable while rate_valid=1 and there is no publish.
  - rate_ready while rate_valid=0 has no effect.
- Overrun:
  - Condition: publish while rate_valid=1 and no transfer on that edge.
  - Response: the new result overwrites, rate_valid stays 1, and overrun pulses high for exactly one cycle.
  - Publish and transfer on the same edge: the old result is consumed, the new one is loaded, rate_valid stays 1, and there is no overrun.
- window_tick in consecutive cycles: each is a full window. A 1-cycle window publishes 0 or 1.

Decomposition:
- Shared package hm_pkg holds:
  - typedef enum logic {ALIGN, MEASURE} rate_state_t
  - default threshold constants HM_LOW_TH=40, HM_HIGH_TH=120, reused by the alarm/display logic
- Sub-module beat_edge_detector:
  - Contains the 2-flop sync, edge flop and refractory lockout (param REFRACT_CYC).
  - Outputs a one-cycle beat_accept.
  - Top level holds the FSM, counter, result registers and handshake.

Test Plan (REFRACT_CYC=4, CNT_W=8, LOW_TH=3, HIGH_TH=5, window_tick every 100 cycles):
1. Reset with beats in the first window, then 4 clean beats 20 cycles apart in the second window, rate_ready=1 -> no result after the first tick; after the second tick rate=4, rate_valid=1 for 1 cycle, both alarms 0.
2. Beat with 3 bounces 1 cycle apart (within lockout), 2 such bursts per window -> rate=2, low_alarm=1, high_alarm=0.
3. 7 beats per window, rate_ready=0 for two windows -> rate=7 and high_alarm=1 held stable; at the second tick overrun pulses 1 cycle; rate_valid stays 1 until rate_ready.
4. Accepted edge on the same clock as window_tick after 3 earlier beats -> published rate=3; the next window starts at count=1.
5. CNT_W=4, 20 beats spaced 5 cycles -> rate=15 (saturated, no wrap).
6. rst_n pulsed low mid-window with rate_valid=1 -> all outputs 0 asynchronously; the next tick produces no result (ALIGN); the following tick publishes normally.
